// File: rtl/async_transmitter_fifo.sv
// -----------------------------------------------------------------------------
// async_transmitter_fifo
//
// RS-232 8N1 serial transmitter with a small byte FIFO in front of it. Bytes
// queued through TxD_start/TxD_data are sent back-to-back on TxD with no idle
// bit between frames. Bit timing comes from a fractional phase accumulator
// stepped at 1x baud.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   TxD_start  write strobe, accepted on an edge where TxD_busy is low
//   TxD_data   byte to queue, sampled at the accepting edge
//   TxD        serial line, idle high
//   TxD_busy   FIFO full, writes ignored while high
//   TxD_idle   FIFO empty and no frame in progress
//   TxD_done   one-clock pulse at the end of each frame's stop bit
// -----------------------------------------------------------------------------
module async_transmitter_fifo #(
    parameter int ClkFrequency          = 80000000,
    parameter int Baud                  = 4800,
    parameter int BaudGeneratorAccWidth = 18,
    parameter int FifoAddrWidth         = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD,
    output logic       TxD_busy,
    output logic       TxD_idle,
    output logic       TxD_done
);

    localparam int W     = BaudGeneratorAccWidth;
    localparam int AW    = FifoAddrWidth;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    // Phase increment, rounded to nearest; 64-bit so large clocks don't overflow.
    localparam longint INC_L = ((longint'(Baud) << (W - 4)) + (longint'(ClkFrequency) >> 5))
                               / (longint'(ClkFrequency) >> 4);
    localparam logic [W:0] INC = INC_L[W:0];

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] START = 4'd1;
    localparam logic [3:0] BIT0  = 4'd2;
    localparam logic [3:0] BIT1  = 4'd3;
    localparam logic [3:0] BIT2  = 4'd4;
    localparam logic [3:0] BIT3  = 4'd5;
    localparam logic [3:0] BIT4  = 4'd6;
    localparam logic [3:0] BIT5  = 4'd7;
    localparam logic [3:0] BIT6  = 4'd8;
    localparam logic [3:0] BIT7  = 4'd9;
    localparam logic [3:0] STOP  = 4'd10;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [W:0] acc;
    logic [W:0] acc_nxt;
    logic [7:0] shreg;
    logic [7:0] shreg_nxt;
    logic       tx_line;
    logic       tx_line_nxt;
    logic       done_pulse;
    logic       baud_tick;
    logic       wr;
    logic       pop;
    logic       fifo_has_data;

    assign baud_tick     = acc[W];
    assign fifo_has_data = (count != '0);
    // Accept test uses the registered full flag, so a pop on the same edge
    // does not make room for a write that arrives while full.
    assign wr            = TxD_start && !TxD_busy;

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        acc_nxt   = {1'b0, acc[W-1:0]} + INC;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                acc_nxt = '0;
                if (fifo_has_data) begin
                    pop       = 1'b1;
                    shreg_nxt = mem[rd_ptr];
                    state_nxt = START;
                    // The popping edge is the first phase step from zero, so
                    // the start bit lasts one full baud period.
                    acc_nxt   = INC;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_nxt = BIT0;
                end
            end
            BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: begin
                if (baud_tick) begin
                    state_nxt = (state == BIT7) ? STOP : state + 4'd1;
                    shreg_nxt = shreg >> 1;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (fifo_has_data) begin
                        // Chain straight into the next start bit; the
                        // accumulator keeps running so phase stays continuous.
                        pop       = 1'b1;
                        shreg_nxt = mem[rd_ptr];
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                        acc_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
            end
        endcase

        // Line level registered from the next state so TxD never glitches.
        case (state_nxt)
            START:                                          tx_line_nxt = 1'b0;
            BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: tx_line_nxt = shreg_nxt[0];
            default:                                        tx_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            tx_line    <= 1'b1;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            tx_line    <= tx_line_nxt;
            done_pulse <= (state == STOP) && baud_tick;
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW + 1)'(wr) - (AW + 1)'(pop);
        end
    end

    // Storage carries data only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= TxD_data;
        end
        shreg <= shreg_nxt;
    end

    assign TxD      = tx_line;
    assign TxD_busy = (count == FULL_CNT);
    assign TxD_idle = (state == IDLE) && (count == '0);
    assign TxD_done = done_pulse;

endmodule
